// File: rtl/ipf_feeder.sv
// ipf_feeder: per-tile fetch/load/fire sequencer for the IPF engine, with a
// 4-entry result FIFO draining engine beats onto a valid/ready stream.
module ipf_feeder #(
    parameter int Addr_Width = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [7:0]            n_tiles,
    input  logic [Addr_Width-1:0] i_base,
    input  logic [Addr_Width-1:0] w_base,
    output logic                  busy,
    output logic                  done,
    output logic                  mem_rd,
    output logic [Addr_Width-1:0] mem_addr,
    input  logic [7:0]            mem_rdata,
    output logic [1:0]            ctrl,
    output logic [7:0]            i_data,
    output logic                  i_valid,
    output logic [3:0]            w_data,
    output logic                  w_valid,
    input  logic [31:0]           res,
    input  logic                  res_valid,
    input  logic                  finish,
    output logic [31:0]           out_data,
    output logic                  out_valid,
    input  logic                  out_ready
);

    typedef enum logic [3:0] {
        IDLE, CHECK, FETCH, LAST, FIRE, STEP, ENDC, WFIN, DONE
    } state_t;

    localparam logic [1:0] CTRL_END   = 2'd0;
    localparam logic [1:0] CTRL_START = 2'd1;
    localparam logic [1:0] CTRL_HOLD  = 2'd2;

    state_t                state, state_next;
    logic [1:0]            phase;
    logic [7:0]            k, n_lat, k_inc;
    logic [Addr_Width-1:0] ip, wp;
    logic                  rd_pend;
    logic [1:0]            rd_idx;

    logic [31:0]           fifo_mem [4];
    logic [1:0]            wr_ptr, rd_ptr;
    logic [2:0]            fifo_count;
    logic                  push, pop;

    assign k_inc = k + 8'd1;

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_next;
    end

    // Next-state logic and engine/memory control outputs
    always_comb begin
        state_next = state;
        ctrl       = CTRL_HOLD;
        mem_rd     = 1'b0;
        mem_addr   = '0;
        case (state)
            IDLE:  if (start) state_next = (n_tiles != 8'd0) ? CHECK : ENDC;
            CHECK: if (fifo_count <= 3'd1) state_next = FETCH;
            FETCH: begin
                mem_rd   = 1'b1;
                mem_addr = (phase == 2'd3) ? wp : ip + Addr_Width'(phase);
                if (phase == 2'd3) state_next = LAST;
            end
            LAST:  state_next = FIRE;
            FIRE: begin
                ctrl = CTRL_START;
                if (phase == 2'd2) state_next = STEP;
            end
            STEP:  state_next = (k_inc == n_lat) ? ENDC : CHECK;
            ENDC: begin
                ctrl       = CTRL_END;
                state_next = WFIN;
            end
            WFIN:  if (finish && fifo_count == 3'd0) state_next = DONE;
            DONE:  state_next = DONE;
            default: state_next = IDLE;
        endcase
    end

    // Per-state cycle counter (restarts on every state change), job registers and pointers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            phase <= '0;
            k     <= '0;
            n_lat <= '0;
            ip    <= '0;
            wp    <= '0;
        end else begin
            phase <= (state_next != state) ? 2'd0 : phase + 2'd1;
            if (state == IDLE && start && n_tiles != 8'd0) begin
                k     <= '0;
                n_lat <= n_tiles;
                ip    <= i_base;
                wp    <= w_base;
            end
            if (state == LAST) begin
                ip <= ip + Addr_Width'(3);
                wp <= wp + Addr_Width'(1);
            end
            if (state == STEP) k <= k_inc;
        end
    end

    // Read-return tracking: data arrives one cycle after the strobe
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_pend <= 1'b0;
            rd_idx  <= '0;
        end else begin
            rd_pend <= mem_rd;
            rd_idx  <= phase;
        end
    end

    assign i_data  = mem_rdata;
    assign w_data  = mem_rdata[3:0];
    assign i_valid = rd_pend && (rd_idx != 2'd3);
    assign w_valid = rd_pend && (rd_idx == 2'd3);
    assign busy    = (state != IDLE) && (state != DONE);
    assign done    = (state == DONE);

    assign push      = res_valid;
    assign pop       = out_valid && out_ready;
    assign out_valid = (fifo_count != 3'd0);
    assign out_data  = fifo_mem[rd_ptr];

    // Result FIFO storage (contents need no reset; validity is tracked by the count)
    always_ff @(posedge clk) begin
        if (push) fifo_mem[wr_ptr] <= res;
    end

    // Result FIFO pointers and occupancy
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 2'd1;
            if (pop)  rd_ptr <= rd_ptr + 2'd1;
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + 3'd1;
                2'b01:   fifo_count <= fifo_count - 3'd1;
                default: fifo_count <= fifo_count;
            endcase
        end
    end

endmodule

// File: doc/ipf_feeder.md
# ipf_feeder

Tile sequencer that drives the IPF compute engine from the feeding side and drains its results. Per tile it fetches three input bytes and one weight nibble from a byte-wide memory, loads them into the engine, issues START/HOLD so the engine produces exactly three result beats, and buffers those beats in a 4-entry result FIFO with a valid/ready output. After the last tile it issues END, waits for the engine's finish, and holds done.

## Interface
- Addr_Width, 16, memory address width; addresses wrap modulo 2^Addr_Width
- clk  in  1  clock, all logic on rising edge
- rst  in  1  asynchronous, active-low reset (0 = reset)
- start  in  1  begin job; sampled only in IDLE
- n_tiles  in  8  tile count, sampled with start
- i_base, w_base  in  Addr_Width  input-byte / weight base addresses, sampled with start
- busy  out  1  high in every state except IDLE and DONE
- done  out  1  level, high in DONE until reset
- mem_rd  out  1  read strobe; mem_addr  out  Addr_Width
- mem_rdata  in  8  read data, valid exactly one cycle after mem_rd
- ctrl  out  2  to engine: 0 END, 1 START, 2 HOLD
- i_data  out  8  = mem_rdata; i_valid  out  1
- w_data  out  4  = mem_rdata[3:0]; w_valid  out  1
- res  in  32, res_valid  in  1, finish  in  1  from engine
- out_data  out  32, out_valid  out  1, out_ready  in  1  result stream

## Operation
- States: IDLE, CHECK, FETCH, LAST, FIRE, STEP, ENDC, WFIN, DONE. ctrl = HOLD in every state except FIRE (START) and ENDC (END).
- IDLE: start & n_tiles!=0 -> CHECK, latch inputs, tile k=0, i pointer = i_base, w pointer = w_base. start & n_tiles==0 -> ENDC.
- CHECK: stay until FIFO count <= 1, then -> FETCH.
- FETCH: 4 cycles, mem_rd=1; addresses ip, ip+1, ip+2, then wp. -> LAST.
- Return path: registered one-cycle delay of read index; returns 0..2 assert i_valid (only), return 3 asserts w_valid (only). Return 3 lands in LAST.
- LAST: 1 cycle -> FIRE. ip += 3, wp += 1.
- FIRE: 3 cycles of ctrl=START -> STEP. STEP: ctrl=HOLD, k += 1; k==n_tiles -> ENDC else CHECK.
- Engine alignment: first START seen in engine WAIT; res_valid beats fall on FIRE cycles 2,3 and STEP; engine returns to WAIT the cycle after STEP with its input registers rotated back to load order.
- FIFO: push whenever res_valid (any state); pop when out_valid & out_ready; simultaneous push/pop leaves count unchanged; out_valid = count!=0; out_data = head entry. CHECK rule guarantees no overflow (max count 4).
- ENDC: 1 cycle ctrl=END -> WFIN. WFIN: finish & FIFO empty -> DONE.
- DONE: terminal (engine is terminal after END); start ignored; exit only via reset.
- start while busy or in DONE: ignored, latched values unchanged.

## Timing
- Reset values: ctrl=2 (HOLD, never END from reset), mem_rd=0, mem_addr=0, i_valid=0, w_valid=0, out_valid=0, busy=0, done=0, FIFO empty, state IDLE.
- Reset asserted mid-job: all of the above immediately; FIFO contents discarded; engine must be reset concurrently.
- Per tile with out_ready=1: CHECK 1 + FETCH 4 + LAST 1 + FIRE 3 + STEP 1 = 10 cycles.
- Earliest first out_valid: cycle after second FIRE cycle (push registered).
- i_valid and w_valid never high together; never high during FIRE/STEP.
- Pointer arithmetic is Addr_Width-bit unsigned, wraps silently.

## Test plan
- Single tile, mem i bytes 0x55,0x55,0x55 at i_base=0x0010, weight 0x0F at w_base=0x0100, out_ready=1 -> reads 0x10,0x11,0x12,0x100; three out beats 0x33333333; ENDC one cycle later; done high after finish.
- n_tiles=0 -> ctrl=END the cycle after start, no mem_rd, no out beats, done after finish.
- n_tiles=4, out_ready=0 -> tile 0 runs, FIFO count 3, FSM stalls in CHECK; raise out_ready -> 12 beats in order, no loss, count never >4.
- i_base=0xFFFE, n_tiles=2 -> addresses 0xFFFE,0xFFFF,0x0000 then 0x0001..0x0003; weights at w_base, w_base+1.
- start pulsed during FETCH and in DONE -> ignored; n_tiles change mid-job has no effect.
- rst=0 during second FIRE cycle -> same cycle ctrl=2, outputs at reset values, FIFO empty; new job after release completes correctly.
